// File: rtl/lpc_reg_arbiter.sv
// Two-requester (Host / Bmc) arbiter for the 32 x 8-bit LPC register bank.
// Fixed 3-cycle transaction: IDLE grant -> ACCESS write strobe -> DONE ack/read.
module lpc_reg_arbiter #(
  parameter int          NUM_REGS = 32,
  parameter logic [7:0]  OOR_DATA = 8'hFF
) (
  input  logic         LpcClock,
  input  logic         PciReset,
  input  logic         HostReq,
  input  logic         HostWr,
  input  logic [7:0]   HostAddr,
  input  logic [7:0]   HostWrData,
  output logic         HostAck,
  output logic [7:0]   HostRdData,
  input  logic         BmcReq,
  input  logic         BmcWr,
  input  logic [7:0]   BmcAddr,
  input  logic [7:0]   BmcWrData,
  output logic         BmcAck,
  output logic [7:0]   BmcRdData,
  input  logic [255:0] RegFile,
  output logic [7:0]   Addr,
  output logic         Wr,
  output logic [7:0]   DataWrSW,
  output logic         AddrErr,
  output logic         Busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic [8:0] NUM_REGS_W = 9'(NUM_REGS);

  state_t     state, state_nxt;
  logic       grant;
  logic       pick_bmc;
  logic [7:0] sel_addr;
  logic       last_bmc;
  logic       gnt_bmc;
  logic       wr_q;
  logic       oor_q;
  logic [7:0] addr_q;
  logic [7:0] data_q;
  logic [7:0] host_rd_q;
  logic [7:0] bmc_rd_q;
  logic [7:0] rd_live;
  logic       done;

  // Under contention the requester that did not get the previous grant wins.
  always_comb begin
    state_nxt = state;
    grant     = 1'b0;
    pick_bmc  = BmcReq & (~HostReq | ~last_bmc);
    case (state)
      IDLE: begin
        if (HostReq || BmcReq) begin
          grant     = 1'b1;
          state_nxt = ACCESS;
        end
      end
      ACCESS:  state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign sel_addr = pick_bmc ? BmcAddr : HostAddr;

  always_ff @(posedge LpcClock) begin
    if (PciReset) begin
      state     <= IDLE;
      last_bmc  <= 1'b1;
      gnt_bmc   <= 1'b0;
      wr_q      <= 1'b0;
      oor_q     <= 1'b0;
      addr_q    <= 8'h00;
      data_q    <= 8'h00;
      host_rd_q <= 8'h00;
      bmc_rd_q  <= 8'h00;
    end else begin
      state <= state_nxt;
      if (grant) begin
        last_bmc <= pick_bmc;
        gnt_bmc  <= pick_bmc;
        wr_q     <= pick_bmc ? BmcWr : HostWr;
        addr_q   <= sel_addr;
        data_q   <= pick_bmc ? BmcWrData : HostWrData;
        oor_q    <= ({1'b0, sel_addr} >= NUM_REGS_W);
      end
      if (state == DONE) begin
        if (gnt_bmc) bmc_rd_q  <= rd_live;
        else         host_rd_q <= rd_live;
      end
    end
  end

  // Read data is taken in DONE so a write returns the bank's post-write value.
  assign rd_live = oor_q ? OOR_DATA : RegFile[{addr_q[4:0], 3'b000} +: 8];

  assign done       = (state == DONE) & ~PciReset;
  assign Wr         = (state == ACCESS) & wr_q & ~oor_q & ~PciReset;
  assign Addr       = addr_q;
  assign DataWrSW   = data_q;
  assign Busy       = (state != IDLE);
  assign HostAck    = done & ~gnt_bmc;
  assign BmcAck     = done & gnt_bmc;
  assign AddrErr    = done & oor_q;
  assign HostRdData = HostAck ? rd_live : host_rd_q;
  assign BmcRdData  = BmcAck ? rd_live : bmc_rd_q;

endmodule

// File: doc/lpc_reg_arbiter.md
Name: lpc_reg_arbiter

Overview:
- Arbitrates access to the LPC register bank (32 x 8-bit) between two requesters: the LPC host cycle decoder (Host) and the BMC/SMBus slave bridge (Bmc).
- Drives the bank's Addr/Wr/DataWrSW write port and returns read data, sampled from the bank's flattened register output, with a per-requester Ack.
- Sits between the Lpc front end and the register bank, in the LpcClock domain.

Parameters:
- NUM_REGS, 32, number of implemented registers; addresses at or above this value are out of range.
- OOR_DATA, 8'hFF, read data returned for an out-of-range address.

Ports:
- LpcClock  in  1  33 MHz LPC clock; the only clock.
- PciReset  in  1  synchronous, active-high reset.
- HostReq  in  1  Host request; held until HostAck.
- HostWr  in  1  1 = write, 0 = read; stable while HostReq is high.
- HostAddr  in  8  register address.
- HostWrData  in  8  write data.
- HostAck  out  1  one-cycle completion pulse.
- HostRdData  out  8  read data, valid while HostAck is high, held afterwards.
- BmcReq, BmcWr, BmcAddr[7:0], BmcWrData[7:0]  in  same meaning as the Host inputs, for Bmc.
- BmcAck  out  1 / BmcRdData  out  8  same meaning as the Host outputs, for Bmc.
- RegFile  in  256  current register contents; byte n = RegFile[8n+7:8n].
- Addr  out  8  register-bank address.
- Wr  out  1  register-bank write strobe.
- DataWrSW  out  8  register-bank write data.
- AddrErr  out  1  pulses with Ack when the address is out of range.
- Busy  out  1  high in every state except IDLE.

Behaviour:
- Clock and reset: one clock, LpcClock. Reset is synchronous, active-high, on PciReset.
- Reset values:
  - state = IDLE, LastGnt = Bmc, so Host wins the first tie.
  - Addr = 0, DataWrSW = 0, Wr = 0, Busy = 0.
  - HostAck = 0, BmcAck = 0, AddrErr = 0.
  - HostRdData = 0, BmcRdData = 0.
- FSM states: IDLE -> ACCESS -> DONE -> IDLE. Every transaction is exactly 3 cycles from grant to Ack.
- IDLE:
  - If any Req is high: select the winner; latch the winner's Wr, Addr, WrData and id; compute OOR = (Addr >= NUM_REGS); go to ACCESS.
  - Otherwise stay in IDLE.
- Arbitration:
  - Only one Req high: that requester wins.
  - Both high: the requester not equal to LastGnt wins. LastGnt updates on every grant (strict alternation under contention).
- ACCESS:
  - Addr and DataWrSW are driven from the latch.
  - Wr = latched Wr AND NOT OOR, asserted for exactly this one cycle.
  - Go to DONE.
- DONE:
  - Ack pulses for the granted requester only.
  - RdData = OOR ? OOR_DATA : RegFile byte[Addr]. For writes this returns the post-write (masked) bank value. This RdData is registered and held until that requester's next Ack.
  - AddrErr = OOR.
  - Go to IDLE.
- Requester rule: Req must be low in the cycle after Ack. A Req still high in IDLE is treated as a new request.
- Req dropped after grant: the transaction still completes and Ack is still issued; no abort path exists.
- A non-granted Req arriving during ACCESS/DONE waits. It is sampled in the next IDLE cycle.
- Addr, DataWrSW, Busy: Addr and DataWrSW hold their last value in IDLE. Busy = (state != IDLE).
- Reset mid-transaction:
  - Return to IDLE immediately; no Ack, no Wr.
  - If reset lands in the ACCESS cycle, Wr is forced to 0 in that cycle.
- Addr width rule: the full 8-bit compare against NUM_REGS is used. Address bits [7:5] are never truncated.

Test Plan:
- Host write, no contention: HostReq with Addr=0x0E, Data=0x15 -> Wr=1 one cycle later with Addr=0x0E, DataWrSW=0x15; HostAck two cycles after grant; HostRdData=0x15 (mask 0x1F passes); BmcAck stays 0.
- Simultaneous requests after reset: both Req high, Host reads 0x00, Bmc reads 0x01 -> Host served first, then Bmc; Bmc Ack lands 3 cycles after HostAck; BmcRdData=0x55.
- Continuous contention: both Req reasserted for 6 transactions -> grants alternate H,B,H,B,H,B; no requester is granted twice in a row.
- Out of range: Bmc write Addr=0x20, Data=0xAB -> Wr never asserts; BmcAck=1 with AddrErr=1 and BmcRdData=0xFF.
- Reset in ACCESS: PciReset high in the Wr cycle -> Wr=0 in that cycle; no Ack; Busy=0 next cycle; bank contents are unchanged.
- Req dropped after grant: HostReq falls during ACCESS -> HostAck still pulses; a pending Bmc request is granted in the following IDLE cycle.
